// File: rtl/shrv_decode_pkg.sv
// Shared types for the shrv32 decode stage.
//   opcode_e  : RV32I major opcodes recognised by decode
//   opclass_e : operation class handed to execute
//   imm_fmt_e : immediate layout selector for imm_gen
package shrv_decode_pkg;

   typedef enum logic [6:0] {
      OP_LUI      = 7'b0110111,
      OP_AUIPC    = 7'b0010111,
      OP_JAL      = 7'b1101111,
      OP_JALR     = 7'b1100111,
      OP_BRANCH   = 7'b1100011,
      OP_LOAD     = 7'b0000011,
      OP_STORE    = 7'b0100011,
      OP_OPIMM    = 7'b0010011,
      OP_OP       = 7'b0110011,
      OP_MISC_MEM = 7'b0001111,
      OP_SYSTEM   = 7'b1110011
   } opcode_e;

   typedef enum logic [3:0] {
      OC_NOP   = 4'd0,
      OC_LUI   = 4'd1,
      OC_AUIPC = 4'd2,
      OC_JAL   = 4'd3,
      OC_JALR  = 4'd4,
      OC_BR    = 4'd5,
      OC_LD    = 4'd6,
      OC_ST    = 4'd7,
      OC_ALUI  = 4'd8,
      OC_ALU   = 4'd9,
      OC_ILL   = 4'd10
   } opclass_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4,
      IMM_R = 3'd5
   } imm_fmt_e;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: combinational, builds the sign-extended RV32I
// immediate for the selected format.
//   instr : instruction bits [31:7]
//   fmt   : immediate format
//   imm   : 32-bit immediate (0 for R-type)
module imm_gen
   import shrv_decode_pkg::*;
(
   input  logic [31:7] instr,
   input  imm_fmt_e    fmt,
   output logic [31:0] imm
);

   always_comb begin
      imm = 32'h0;
      case (fmt)
         IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U: imm = {instr[31:12], 12'h0};
         IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'h0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage of the shrv32 core.
// Splits the fetched word into fields, builds the immediate, classifies the
// operation and holds the result for execute. A pending-writeback scoreboard
// stalls fetch on RAW/WAW hazards since the register file has no bypass.
//   RST, CLK_DC           : async active-low reset, decode clock
//   if_*                  : fetch handshake (valid/instr/pc in, ready out)
//   A1, A2                : register-file read addresses, straight from if_instr
//   id_*                  : registered decode result and execute handshake
//   wb_clr, wb_rd         : writeback completion, clears a pending bit
//   flush                 : kills the held instruction
module decode_stage
   import shrv_decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            RST,
   input  logic            CLK_DC,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_ready,
   output logic [4:0]      A1,
   output logic [4:0]      A2,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [4:0]      id_rd,
   output logic [31:0]     id_imm,
   output logic [2:0]      id_funct3,
   output logic            id_funct7b5,
   output opclass_e        id_opclass,
   output logic            id_illegal,
   input  logic            wb_clr,
   input  logic [4:0]      wb_rd,
   input  logic            flush
);

   logic [4:0]      rs1, rs2, rd;
   logic [6:0]      opcode;
   opclass_e        opclass;
   imm_fmt_e        fmt;
   logic            uses_rs1, uses_rs2, rd_field, writes_rd, illegal;
   logic [31:0]     imm;
   logic            hazard, accept;
   logic [NREG-1:0] pend, pend_nxt;

   assign opcode = if_instr[6:0];
   assign rs1    = if_instr[19:15];
   assign rs2    = if_instr[24:20];
   assign rd     = if_instr[11:7];
   assign A1     = rs1;
   assign A2     = rs2;

   always_comb begin
      opclass  = OC_ILL;
      fmt      = IMM_R;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      rd_field = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OP_LUI:      begin opclass = OC_LUI;   fmt = IMM_U; rd_field = 1'b1; end
         OP_AUIPC:    begin opclass = OC_AUIPC; fmt = IMM_U; rd_field = 1'b1; end
         OP_JAL:      begin opclass = OC_JAL;   fmt = IMM_J; rd_field = 1'b1; end
         OP_JALR:     begin opclass = OC_JALR;  fmt = IMM_I; rd_field = 1'b1; uses_rs1 = 1'b1; end
         OP_BRANCH:   begin opclass = OC_BR;    fmt = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_LOAD:     begin opclass = OC_LD;    fmt = IMM_I; rd_field = 1'b1; uses_rs1 = 1'b1; end
         OP_STORE:    begin opclass = OC_ST;    fmt = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_OPIMM:    begin opclass = OC_ALUI;  fmt = IMM_I; rd_field = 1'b1; uses_rs1 = 1'b1; end
         OP_OP:       begin opclass = OC_ALU;   fmt = IMM_R; rd_field = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OP_MISC_MEM: begin opclass = OC_NOP;   fmt = IMM_I; end
         OP_SYSTEM:   begin opclass = OC_NOP;   fmt = IMM_I; end
         default:     illegal = 1'b1;
      endcase
      // every recognised opcode ends in 2'b11; this keeps the rule explicit
      if (if_instr[1:0] != 2'b11) begin
         illegal  = 1'b1;
         opclass  = OC_ILL;
         fmt      = IMM_R;
         uses_rs1 = 1'b0;
         uses_rs2 = 1'b0;
         rd_field = 1'b0;
      end
   end

   assign writes_rd = rd_field && (rd != 5'd0);

   imm_gen u_imm_gen (
      .instr (if_instr[31:7]),
      .fmt   (fmt),
      .imm   (imm)
   );

   // registered pend only: a same-cycle writeback does not release the stall
   assign hazard = (uses_rs1 && (rs1 != 5'd0) && pend[rs1]) ||
                   (uses_rs2 && (rs2 != 5'd0) && pend[rs2]) ||
                   (writes_rd && pend[rd]);

   assign if_ready = !flush && !hazard && (!id_valid || id_ready);
   assign accept   = if_valid && if_ready;

   // clear first, then set, so an accept wins over a writeback on the same index
   always_comb begin
      pend_nxt = pend;
      if (wb_clr)
         pend_nxt[wb_rd] = 1'b0;
      if (flush && id_valid)
         pend_nxt[id_rd] = 1'b0;
      if (accept && writes_rd)
         pend_nxt[rd] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge CLK_DC or negedge RST) begin
      if (!RST) begin
         pend        <= '0;
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_rd       <= 5'd0;
         id_imm      <= 32'h0;
         id_funct3   <= 3'd0;
         id_funct7b5 <= 1'b0;
         id_opclass  <= OC_NOP;
         id_illegal  <= 1'b0;
      end else begin
         pend <= pend_nxt;
         if (flush) begin
            id_valid <= 1'b0;
         end else if (accept) begin
            id_valid    <= 1'b1;
            id_pc       <= if_pc;
            id_rd       <= writes_rd ? rd : 5'd0;
            id_imm      <= imm;
            id_funct3   <= if_instr[14:12];
            id_funct7b5 <= if_instr[30];
            id_opclass  <= opclass;
            id_illegal  <= illegal;
         end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the shrv32 core, clocked on CLK_DC.
- Sits between the fetch stage and the execute stage, and drives the register-file read addresses.
- Splits each RV32I instruction into fields, generates the immediate, and classifies the operation.
- Tracks pending writebacks in a 32-bit scoreboard and stalls fetch on RAW/WAW hazards, because the register file has no bypass.

Parameters:
- XLEN, 32, datapath and PC width.
- NREG, 32, number of architectural registers (scoreboard size).

Ports:
- RST  in  1  asynchronous, active-low reset
- CLK_DC  in  1  decode clock; all state updates on its posedge
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- if_ready  out  1  decode accepts this cycle
- A1  out  5  rs1 read address to the register file (combinational from if_instr)
- A2  out  5  rs2 read address to the register file (combinational from if_instr)
- id_valid  out  1  decoded instruction held for execute
- id_ready  in  1  execute consumes this cycle
- id_pc  out  XLEN  registered PC
- id_rd  out  5  destination register; 0 if none
- id_imm  out  32  sign-extended immediate
- id_funct3  out  3  funct3 field
- id_funct7b5  out  1  instr[30]
- id_opclass  out  4  operation class (package enum)
- id_illegal  out  1  unrecognised encoding
- wb_clr  in  1  a writeback completed (synchronous to CLK_DC)
- wb_rd  in  5  register written by that writeback
- flush  in  1  kill the held instruction (branch redirect)

Behaviour:
- Reset (RST low, async):
  - id_valid=0; id_pc, id_rd, id_imm, id_funct3, id_funct7b5, id_illegal all 0; id_opclass=OC_NOP.
  - Scoreboard cleared.
- Read addresses: A1=if_instr[19:15], A2=if_instr[24:20], always, regardless of handshake. The register file samples on the same CLK_DC edge, so RD1/RD2 line up with the id_* outputs one cycle later.
- Field use:
  - uses_rs1 for JALR, BRANCH, LOAD, STORE, OPIMM, OP.
  - uses_rs2 for BRANCH, STORE, OP.
  - writes_rd for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, and only when rd!=0.
- Hazard (combinational):
  - (uses_rs1 && rs1!=0 && pend[rs1]) || (uses_rs2 && rs2!=0 && pend[rs2]) || (writes_rd && pend[rd]).
  - Uses the registered pend; a wb_clr in the same cycle does not remove the stall (no bypass).
- if_ready = !flush && !hazard && (!id_valid || id_ready).
- Accept = if_valid && if_ready. On accept:
  - Output register loads decoded fields; id_valid=1.
  - Sets pend[rd] if writes_rd && !illegal.
- Consume without accept (id_valid && id_ready && !accept): id_valid=0; other outputs hold their values.
- Immediate formats:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'h0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended from bit 31. R-type immediate = 0.
- Illegal encodings:
  - Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC_MEM, SYSTEM}, or instr[1:0]!=2'b11.
  - Result: id_illegal=1, id_opclass=OC_ILL, id_rd=0, no scoreboard set.
  - The instruction is still passed downstream.
- MISC_MEM and SYSTEM decode to OC_NOP with id_rd=0.
- Scoreboard update order within one edge: wb_clr clears pend[wb_rd], then the accept sets pend[rd], so set wins on the same index. wb_clr with wb_rd=0 has no effect; pend[0] is always 0.
- Flush:
  - id_valid=0 next edge; no accept that cycle.
  - If the killed instruction had id_valid && id_rd!=0, its pend bit is cleared.
  - wb_clr is still honoured in the same cycle.
- wb_clr for a register whose pend bit is 0: ignored, no error.

Decomposition:
- Package shrv_decode_pkg:
  - opcode_e constants (7'b0110111 LUI … 7'b1110011 SYSTEM).
  - opclass_e (4-bit: OC_NOP, OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_BR, OC_LD, OC_ST, OC_ALUI, OC_ALU, OC_ILL).
  - imm_fmt_e (I, S, B, U, J, R).
- Sub-module imm_gen: combinational, inputs instr[31:7] and imm_fmt_e, output 32-bit immediate.
- Scoreboard, handshake, and output register stay in decode_stage.

Test Plan:
- Reset, then if_valid=1 with if_instr=32'h00500093 (addi x1,x0,5), id_ready=1:
  - A1=0 immediately.
  - Next cycle: id_valid=1, id_rd=1, id_imm=5, id_opclass=OC_ALUI; pend[1]=1.
- RAW: after addi x1, present 32'h00108133 (add x2,x1,x1):
  - if_ready=0 until wb_clr=1, wb_rd=1.
  - Accepted on the first cycle after the clear edge; id_rd=2.
- Immediate check: 32'hFE000EE3 (beq x0,x0,-4) gives id_imm=32'hFFFFFFFC, id_rd=0.
- Immediate check: 32'h800000EF (jal x1,-1MiB) gives id_imm=32'hFFF00000.
- Backpressure: id_ready=0 with id_valid=1:
  - if_ready=0; outputs hold across 3 cycles.
  - Raising id_ready accepts the next instruction the same cycle.
- Flush of a held lw x5: pend[5] returns to 0 and id_valid=0. A following 32'hFFFFFFFF gives id_illegal=1, id_rd=0, pend unchanged.
- Async reset asserted mid-stall: id_valid=0 and pend=0 immediately; if_ready=1 after release.
